ex_mem_alu_stage: RTL and testbench
===================================

Name: ex_mem_alu_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Consumes the 3-bit ALU select produced by the ALU control decoder, plus ID/EX operands and control bits.
- Computes the ALU result and zero flag, then registers them with the forwarded control and destination fields into the EX/MEM pipeline latch.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- DATA_W, 32, operand/result width
- REG_ADDR_W, 5, destination register index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  ID/EX slot holds a real instruction
- select  in  3  ALU operation from ALU control decoder
- op_a  in  DATA_W  operand A (rs value)
- op_b  in  DATA_W  operand B (rt value or sign-extended imm, muxed upstream)
- store_data_in  in  DATA_W  rt value for sw
- rd_in  in  REG_ADDR_W  destination register
- regwrite_in, memread_in, memwrite_in, memtoreg_in, branch_in  in  1 each  control bits from ID/EX
- stall  in  1  hold EX/MEM contents
- flush  in  1  load a bubble into EX/MEM
- out_valid  out  1  EX/MEM slot valid
- alu_result  out  DATA_W  registered ALU result
- zero  out  1  registered (result == 0)
- illegal_op  out  1  registered: select was not a defined encoding
- store_data_out  out  DATA_W  registered store data
- rd_out  out  REG_ADDR_W  registered destination
- regwrite_out, memread_out, memwrite_out, memtoreg_out, branch_out  out  1 each  registered control

Behaviour:
- Single clock clk. Reset is synchronous, active-low on rst_n. All state updates on the rising edge of clk.
- Reset (rst_n=0 at the edge): every output register cleared to 0, including out_valid, zero, illegal_op, all data and control.
- Latency: exactly 1 cycle from inputs to registered outputs when loading. No combinational input-to-output path.
- Per-edge priority: reset > flush > stall > load.
- Flush: load a bubble. Bubble means out_valid=0 and every data and control output 0. Flush overrides a simultaneous stall.
- Stall (flush=0): all output registers keep their current value.
- Load (no stall, no flush):
  - in_valid=0: load a bubble.
  - in_valid=1: load computed values.
- ALU operations, all arithmetic modulo 2^DATA_W with no overflow trap:
  - 000: AND
  - 001: OR
  - 010: ADD
  - 110: SUB (a − b)
  - 111: SLT, signed two's-complement compare; result is 1 or 0, zero-extended.
- Illegal select (011, 100, 101) with in_valid=1:
  - Register alu_result=0, zero=0, illegal_op=1, out_valid=1.
  - Force regwrite_out, memwrite_out and memread_out to 0, so no architectural side effect.
  - rd_out, memtoreg_out and branch_out pass through unchanged.
- zero = (computed result == 0) for legal ops only. A beq using SUB with equal operands registers zero=1.
- Reset asserted during a stall: reset wins, and the stall is ignored that cycle.
- stall/flush are sampled only at the edge. A held stall preserves contents indefinitely.

Decomposition:
- Shared package mips_pkg:
  - ALU select constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111, ALU_X=3'b011.
  - DATA_W and REG_ADDR_W defaults.
  - These are the same encodings the ALU control decoder emits, so both blocks import one source.
- One combinational sub-module, alu_core:
  - Inputs: select, a, b.
  - Outputs: result, zero, illegal.
  - ex_mem_alu_stage instantiates it and adds the pipeline register and stall/flush logic.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with nonzero inputs and in_valid=1 -> all outputs 0. Release, then ADD a=5, b=7 -> next edge alu_result=12, zero=0, out_valid=1.
- Arithmetic edges:
  - ADD 0xFFFFFFFF+1 -> 0, zero=1.
  - SUB 0x80000000−1 -> 0x7FFFFFFF.
  - SLT a=0xFFFFFFFF (−1), b=1 -> 1.
  - SLT a=1, b=0xFFFFFFFF -> 0.
- Logic and beq:
  - AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0.
  - OR of the same operands -> 0xFFF0FFF0.
  - SUB a=b=0x1234 with branch_in=1 -> zero=1, branch_out=1.
- Illegal: select=011, regwrite_in=1, memwrite_in=1, rd_in=9 -> illegal_op=1, alu_result=0, regwrite_out=0, memwrite_out=0, rd_out=9, out_valid=1.
- Stall/flush:
  - Load ADD result 12, then stall=1 for 3 cycles with new inputs -> outputs stay at 12.
  - Then stall=1 and flush=1 together -> bubble (out_valid=0, all 0).
  - in_valid=0 with no stall -> bubble.
- Back-to-back loads: stream 4 ops on consecutive cycles (AND, OR, ADD, SLT) -> each result appears exactly one edge later, in order.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU select encodings and default widths.
// The ALU control decoder and the execute stage both import this package.
package mips_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_X   = 3'b011,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_sel_e;

endpackage

// File: rtl/alu_core.sv
// Combinational MIPS ALU: AND/OR/ADD/SUB/SLT, zero flag and illegal-select detect.
module alu_core
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        select,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (select)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: illegal = 1'b1;
    endcase
  end

  // Undefined selects never report zero, so a bogus beq cannot be taken.
  assign zero = !illegal && (result == '0);

endmodule

// File: rtl/ex_mem_alu_stage.sv
// MIPS execute stage: ALU plus the EX/MEM pipeline latch with stall and flush.
// Illegal selects register a valid slot with all architectural writes suppressed.
module ex_mem_alu_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [2:0]            select,
  input  logic [DATA_W-1:0]     op_a,
  input  logic [DATA_W-1:0]     op_b,
  input  logic [DATA_W-1:0]     store_data_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  regwrite_in,
  input  logic                  memread_in,
  input  logic                  memwrite_in,
  input  logic                  memtoreg_in,
  input  logic                  branch_in,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     alu_result,
  output logic                  zero,
  output logic                  illegal_op,
  output logic [DATA_W-1:0]     store_data_out,
  output logic [REG_ADDR_W-1:0] rd_out,
  output logic                  regwrite_out,
  output logic                  memread_out,
  output logic                  memwrite_out,
  output logic                  memtoreg_out,
  output logic                  branch_out
);

  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;
  logic              alu_illegal;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .select  (select),
    .a       (op_a),
    .b       (op_b),
    .result  (alu_res),
    .zero    (alu_zero),
    .illegal (alu_illegal)
  );

  // Reset, flush and an unstalled empty slot all produce the same bubble.
  always_ff @(posedge clk) begin
    if (!rst_n || flush || (!stall && !in_valid)) begin
      out_valid      <= 1'b0;
      alu_result     <= '0;
      zero           <= 1'b0;
      illegal_op     <= 1'b0;
      store_data_out <= '0;
      rd_out         <= '0;
      regwrite_out   <= 1'b0;
      memread_out    <= 1'b0;
      memwrite_out   <= 1'b0;
      memtoreg_out   <= 1'b0;
      branch_out     <= 1'b0;
    end else if (!stall) begin
      out_valid      <= 1'b1;
      alu_result     <= alu_res;
      zero           <= alu_zero;
      illegal_op     <= alu_illegal;
      store_data_out <= store_data_in;
      rd_out         <= rd_in;
      regwrite_out   <= regwrite_in & ~alu_illegal;
      memread_out    <= memread_in  & ~alu_illegal;
      memwrite_out   <= memwrite_in & ~alu_illegal;
      memtoreg_out   <= memtoreg_in;
      branch_out     <= branch_in;
    end
  end

endmodule

// File: tb/tb_ex_mem_alu_stage.sv
// Directed self-checking bench for ex_mem_alu_stage.
module tb_ex_mem_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  select;
  logic [31:0] op_a, op_b, store_data_in;
  logic [4:0]  rd_in;
  logic        regwrite_in, memread_in, memwrite_in, memtoreg_in, branch_in;
  logic        stall, flush;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        zero, illegal_op;
  logic [31:0] store_data_out;
  logic [4:0]  rd_out;
  logic        regwrite_out, memread_out, memwrite_out, memtoreg_out, branch_out;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  ex_mem_alu_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .select(select),
    .op_a(op_a), .op_b(op_b), .store_data_in(store_data_in), .rd_in(rd_in),
    .regwrite_in(regwrite_in), .memread_in(memread_in), .memwrite_in(memwrite_in),
    .memtoreg_in(memtoreg_in), .branch_in(branch_in),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .alu_result(alu_result), .zero(zero),
    .illegal_op(illegal_op), .store_data_out(store_data_out), .rd_out(rd_out),
    .regwrite_out(regwrite_out), .memread_out(memread_out),
    .memwrite_out(memwrite_out), .memtoreg_out(memtoreg_out),
    .branch_out(branch_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [4:0] ctl,
                       input logic [31:0] sd);
    in_valid      = v;
    select        = sel;
    op_a          = a;
    op_b          = b;
    rd_in         = rd;
    {regwrite_in, memread_in, memwrite_in, memtoreg_in, branch_in} = ctl;
    store_data_in = sd;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // ctl order: regwrite, memread, memwrite, memtoreg, branch
  task automatic expect_out(input string tag, input logic v, input logic [31:0] res,
                            input logic z, input logic ill, input logic [4:0] rd,
                            input logic [4:0] ctl, input logic [31:0] sd);
    check({tag, ".valid"},   {31'd0, out_valid},  {31'd0, v});
    check({tag, ".result"},  alu_result,          res);
    check({tag, ".zero"},    {31'd0, zero},       {31'd0, z});
    check({tag, ".illegal"}, {31'd0, illegal_op}, {31'd0, ill});
    check({tag, ".rd"},      {27'd0, rd_out},     {27'd0, rd});
    check({tag, ".ctl"},
          {27'd0, regwrite_out, memread_out, memwrite_out, memtoreg_out, branch_out},
          {27'd0, ctl});
    check({tag, ".sdata"},   store_data_out,      sd);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 3'b010, 32'd5, 32'd7, 5'd3, 5'b11111, 32'hAAAA_5555);
    step;
    step;
    expect_out("reset", 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 5'b00000, 32'd0);

    rst_n = 1'b1;
    drive(1'b1, 3'b010, 32'd5, 32'd7, 5'd3, 5'b10000, 32'h0000_00AB);
    step;
    expect_out("add5_7", 1'b1, 32'd12, 1'b0, 1'b0, 5'd3, 5'b10000, 32'h0000_00AB);

    drive(1'b1, 3'b010, 32'hFFFF_FFFF, 32'd1, 5'd4, 5'b10000, 32'd0);
    step;
    expect_out("add_wrap", 1'b1, 32'd0, 1'b1, 1'b0, 5'd4, 5'b10000, 32'd0);

    drive(1'b1, 3'b110, 32'h8000_0000, 32'd1, 5'd5, 5'b10000, 32'd0);
    step;
    expect_out("sub_min", 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 5'd5, 5'b10000, 32'd0);

    drive(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 5'd6, 5'b10000, 32'd0);
    step;
    expect_out("slt_neg", 1'b1, 32'd1, 1'b0, 1'b0, 5'd6, 5'b10000, 32'd0);

    drive(1'b1, 3'b111, 32'd1, 32'hFFFF_FFFF, 5'd6, 5'b10000, 32'd0);
    step;
    expect_out("slt_pos", 1'b1, 32'd0, 1'b1, 1'b0, 5'd6, 5'b10000, 32'd0);

    drive(1'b1, 3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd7, 5'b10000, 32'd0);
    step;
    expect_out("and", 1'b1, 32'h00F0_00F0, 1'b0, 1'b0, 5'd7, 5'b10000, 32'd0);

    drive(1'b1, 3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd8, 5'b10000, 32'd0);
    step;
    expect_out("or", 1'b1, 32'hFFF0_FFF0, 1'b0, 1'b0, 5'd8, 5'b10000, 32'd0);

    drive(1'b1, 3'b110, 32'h0000_1234, 32'h0000_1234, 5'd0, 5'b00001, 32'd0);
    step;
    expect_out("beq", 1'b1, 32'd0, 1'b1, 1'b0, 5'd0, 5'b00001, 32'd0);

    drive(1'b1, 3'b011, 32'd5, 32'd7, 5'd9, 5'b11111, 32'h1111_2222);
    step;
    expect_out("ill011", 1'b1, 32'd0, 1'b0, 1'b1, 5'd9, 5'b00011, 32'h1111_2222);

    drive(1'b1, 3'b100, 32'd0, 32'd0, 5'd10, 5'b10100, 32'd0);
    step;
    expect_out("ill100", 1'b1, 32'd0, 1'b0, 1'b1, 5'd10, 5'b00000, 32'd0);

    drive(1'b1, 3'b101, 32'd3, 32'd3, 5'd11, 5'b01001, 32'd0);
    step;
    expect_out("ill101", 1'b1, 32'd0, 1'b0, 1'b1, 5'd11, 5'b00001, 32'd0);

    drive(1'b1, 3'b010, 32'd5, 32'd7, 5'd3, 5'b10000, 32'h0000_00CD);
    step;
    expect_out("preload", 1'b1, 32'd12, 1'b0, 1'b0, 5'd3, 5'b10000, 32'h0000_00CD);

    stall = 1'b1;
    drive(1'b1, 3'b010, 32'd1, 32'd1, 5'd7, 5'b01100, 32'h0000_0001);
    step;
    expect_out("stall1", 1'b1, 32'd12, 1'b0, 1'b0, 5'd3, 5'b10000, 32'h0000_00CD);
    drive(1'b1, 3'b110, 32'd9, 32'd9, 5'd8, 5'b00001, 32'd2);
    step;
    expect_out("stall2", 1'b1, 32'd12, 1'b0, 1'b0, 5'd3, 5'b10000, 32'h0000_00CD);
    drive(1'b0, 3'b011, 32'd2, 32'd2, 5'd9, 5'b11111, 32'd3);
    step;
    expect_out("stall3", 1'b1, 32'd12, 1'b0, 1'b0, 5'd3, 5'b10000, 32'h0000_00CD);

    flush = 1'b1;
    drive(1'b1, 3'b010, 32'd1, 32'd2, 5'd4, 5'b11111, 32'd4);
    step;
    expect_out("flush_stall", 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 5'b00000, 32'd0);

    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 3'b010, 32'd20, 32'd22, 5'd12, 5'b10010, 32'd5);
    step;
    expect_out("reload", 1'b1, 32'd42, 1'b0, 1'b0, 5'd12, 5'b10010, 32'd5);

    drive(1'b0, 3'b010, 32'd20, 32'd22, 5'd12, 5'b10010, 32'd5);
    step;
    expect_out("invalid", 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 5'b00000, 32'd0);

    drive(1'b1, 3'b000, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd1, 5'b10000, 32'd0);
    step;
    expect_out("s_and", 1'b1, 32'h0F00_0F00, 1'b0, 1'b0, 5'd1, 5'b10000, 32'd0);
    drive(1'b1, 3'b001, 32'h0000_00F0, 32'h0000_000F, 5'd2, 5'b10000, 32'd0);
    step;
    expect_out("s_or", 1'b1, 32'h0000_00FF, 1'b0, 1'b0, 5'd2, 5'b10000, 32'd0);
    drive(1'b1, 3'b010, 32'd100, 32'hFFFF_FFFE, 5'd3, 5'b10000, 32'd0);
    step;
    expect_out("s_add", 1'b1, 32'd98, 1'b0, 1'b0, 5'd3, 5'b10000, 32'd0);
    drive(1'b1, 3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 5'd4, 5'b10000, 32'd0);
    step;
    expect_out("s_slt", 1'b1, 32'd1, 1'b0, 1'b0, 5'd4, 5'b10000, 32'd0);

    stall = 1'b1;
    rst_n = 1'b0;
    drive(1'b1, 3'b010, 32'd5, 32'd7, 5'd3, 5'b11111, 32'd9);
    step;
    expect_out("rst_stall", 1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 5'b00000, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
